// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the datapath: instruction/flag
// inputs toward the sequencer, register-select, bus and memory strobes back out.
interface control_sequencer_if;
    logic [31:0] IR;
    logic        CON;
    logic        stop;

    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zlowout, Cout, CONin, Read, Write;
    logic [3:0]  alu_op;
    logic        run;
    logic        clear_out;

    modport master (
        input  IR, CON, stop,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
        output Yin, Zin, Zlowout, Cout, CONin, Read, Write,
        output alu_op, run, clear_out
    );

    modport slave (
        output IR, CON, stop,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
        input  Yin, Zin, Zlowout, Cout, CONin, Read, Write,
        input  alu_op, run, clear_out
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit: walks fetch (T0-T2) then an opcode-specific execute
// sequence (T3-T7), decoding every strobe from the current step and opcode.
module control_sequencer (
    input  logic                  clock,
    input  logic                  reset_n,
    control_sequencer_if.master   bus
);

    typedef enum logic [3:0] {
        RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } seqState_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11011;
    localparam logic [3:0] ALU_ADD = 4'b0011;

    seqState_t  state_q, state_d;
    seqState_t  finishState;
    logic [4:0] opcode;
    logic       unusedIrBits;

    assign opcode       = bus.IR[31:27];
    assign unusedIrBits = ^bus.IR[26:0];
    // Last step of every instruction goes here: stop diverts to HALT.
    assign finishState  = bus.stop ? HALT : T0;

    always_ff @(posedge clock) begin
        if (!reset_n) state_q <= RST;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.Gra       = 1'b0;
        bus.Grb       = 1'b0;
        bus.Grc       = 1'b0;
        bus.Rin       = 1'b0;
        bus.Rout      = 1'b0;
        bus.BAout     = 1'b0;
        bus.PCout     = 1'b0;
        bus.PCin      = 1'b0;
        bus.IncPC     = 1'b0;
        bus.MARin     = 1'b0;
        bus.MDRin     = 1'b0;
        bus.MDRout    = 1'b0;
        bus.IRin      = 1'b0;
        bus.Yin       = 1'b0;
        bus.Zin       = 1'b0;
        bus.Zlowout   = 1'b0;
        bus.Cout      = 1'b0;
        bus.CONin     = 1'b0;
        bus.Read      = 1'b0;
        bus.Write     = 1'b0;
        bus.alu_op    = 4'b0000;
        bus.clear_out = 1'b0;
        bus.run       = (state_q != RST) && (state_q != HALT);

        case (state_q)
            RST: begin
                bus.clear_out = 1'b1;
                state_d       = T0;
            end
            T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Zin    = 1'b1;
                bus.alu_op = ALU_ADD;
                state_d    = T1;
            end
            T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                state_d     = T2;
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_d    = T3;
            end
            T3: begin
                state_d = T4;
                case (opcode)
                    OP_LD, OP_LDI, OP_ST: begin
                        bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
                    end
                    OP_BR: begin
                        bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1;
                    end
                    OP_HALT: state_d = HALT;
                    default: state_d = finishState;
                endcase
            end
            T4: begin
                state_d = T5;
                case (opcode)
                    OP_LD, OP_LDI, OP_ST, OP_ADDI: begin
                        bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = ALU_ADD;
                    end
                    // R-format ops carry their ALU function in the low opcode bits.
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1;
                        bus.alu_op = bus.IR[30:27];
                    end
                    OP_BR: begin
                        bus.PCout = 1'b1; bus.Yin = 1'b1;
                    end
                    default: state_d = finishState;
                endcase
            end
            T5: begin
                state_d = finishState;
                case (opcode)
                    OP_LD, OP_ST: begin
                        bus.Zlowout = 1'b1; bus.MARin = 1'b1; state_d = T6;
                    end
                    OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                        bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                    end
                    OP_BR: begin
                        bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = ALU_ADD;
                        state_d = T6;
                    end
                    default: ;
                endcase
            end
            T6: begin
                state_d = finishState;
                case (opcode)
                    OP_LD: begin
                        bus.Read = 1'b1; bus.MDRin = 1'b1; state_d = T7;
                    end
                    OP_ST: begin
                        bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
                        state_d = T7;
                    end
                    OP_BR: begin
                        bus.Zlowout = bus.CON;
                        bus.PCin    = bus.CON;
                    end
                    default: ;
                endcase
            end
            T7: begin
                state_d = finishState;
                case (opcode)
                    OP_LD: begin
                        bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                    end
                    OP_ST: bus.Write = 1'b1;
                    default: ;
                endcase
            end
            HALT: state_d = HALT;
            default: state_d = RST;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: each task walks one instruction step by
// step and compares the full output word {clear_out, run, alu_op, strobes}.
module tb_control_sequencer;

    localparam logic [19:0] GRA = 20'h80000, GRB = 20'h40000, GRC = 20'h20000;
    localparam logic [19:0] RIN = 20'h10000, ROUT = 20'h08000, BAOUT = 20'h04000;
    localparam logic [19:0] PCOUT = 20'h02000, PCIN = 20'h01000, INCPC = 20'h00800;
    localparam logic [19:0] MARIN = 20'h00400, MDRIN = 20'h00200, MDROUT = 20'h00100;
    localparam logic [19:0] IRIN = 20'h00080, YIN = 20'h00040, ZIN = 20'h00020;
    localparam logic [19:0] ZLOWOUT = 20'h00010, COUT = 20'h00008, CONIN = 20'h00004;
    localparam logic [19:0] READ = 20'h00002, WRITE = 20'h00001;

    localparam logic [1:0] RUNV = 2'b01;
    localparam logic [3:0] ADD = 4'b0011, NA = 4'b0000;
    localparam logic [25:0] F0   = {RUNV, ADD, PCOUT | MARIN | INCPC | ZIN};
    localparam logic [25:0] F1   = {RUNV, NA, ZLOWOUT | PCIN | READ | MDRIN};
    localparam logic [25:0] F2   = {RUNV, NA, MDROUT | IRIN};
    localparam logic [25:0] RSTV = {2'b10, NA, 20'h0};
    localparam logic [25:0] HLTV = 26'h0;
    localparam logic [25:0] IDLE = {RUNV, NA, 20'h0};

    logic clock;
    logic reset_n;
    int   total = 0;
    int   bad = 0;

    control_sequencer_if bus();

    control_sequencer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [25:0] obsVec();
        return {bus.clear_out, bus.run, bus.alu_op,
                bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout,
                bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout,
                bus.IRin, bus.Yin, bus.Zin, bus.Zlowout, bus.Cout, bus.CONin,
                bus.Read, bus.Write};
    endfunction

    // Leaves the DUT sitting in T0, sampled 1 time unit after the edge.
    task automatic applyStimulus();
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        logic [25:0] expv [5];
        expv = '{RSTV, RSTV, F0, F1, F2};
        bus.IR = 32'hD0000000;
        reset_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            if (i == 1) reset_n = 1'b1;
            total++;
            if (obsVec() !== expv[i]) begin
                bad++;
                $display("[TB] FAIL reset_fetch step%0d: got %h want %h", i, obsVec(), expv[i]);
            end
        end
    endtask

    task automatic test_nop();
        logic [31:0] irs [2];
        irs = '{32'hD0000000, 32'h78000000};
        for (int k = 0; k < 2; k++) begin
            logic [25:0] expv [5];
            expv = '{F0, F1, F2, IDLE, F0};
            applyStimulus();
            bus.IR = irs[k];
            for (int i = 0; i < 5; i++) begin
                if (i > 0) begin @(posedge clock); #1; end
                total++;
                if (obsVec() !== expv[i]) begin
                    bad++;
                    $display("[TB] FAIL nop ir=%h step%0d: got %h want %h", irs[k], i, obsVec(), expv[i]);
                end
            end
        end
    endtask

    task automatic test_ld();
        logic [25:0] expv [9];
        expv = '{F0, F1, F2, {RUNV, NA, GRB | BAOUT | YIN}, {RUNV, ADD, COUT | ZIN},
                 {RUNV, NA, ZLOWOUT | MARIN}, {RUNV, NA, READ | MDRIN},
                 {RUNV, NA, MDROUT | GRA | RIN}, F0};
        applyStimulus();
        bus.IR = 32'h01000055;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin @(posedge clock); #1; end
            total++;
            if (obsVec() !== expv[i]) begin
                bad++;
                $display("[TB] FAIL ld step%0d: got %h want %h", i, obsVec(), expv[i]);
            end
        end
    endtask

    task automatic test_rformat();
        logic [31:0] irs [3];
        irs = '{32'h1A920000, 32'h20000000, 32'h30000000};
        for (int k = 0; k < 3; k++) begin
            logic [25:0] expv [7];
            expv = '{F0, F1, F2, {RUNV, NA, GRB | ROUT | YIN},
                     {RUNV, irs[k][30:27], GRC | ROUT | ZIN},
                     {RUNV, NA, ZLOWOUT | GRA | RIN}, F0};
            applyStimulus();
            bus.IR = 32'hD8000000;
            for (int i = 0; i < 7; i++) begin
                if (i > 0) begin @(posedge clock); #1; end
                if (i == 2) bus.IR = irs[k];
                total++;
                if (obsVec() !== expv[i]) begin
                    bad++;
                    $display("[TB] FAIL rfmt ir=%h step%0d: got %h want %h", irs[k], i, obsVec(), expv[i]);
                end
            end
        end
    endtask

    task automatic test_immediate();
        logic [31:0] irs [2];
        irs = '{32'h08800012, 32'h61000007};
        for (int k = 0; k < 2; k++) begin
            logic [25:0] expv [7];
            expv = '{F0, F1, F2,
                     {RUNV, NA, GRB | ((k == 0) ? BAOUT : ROUT) | YIN},
                     {RUNV, ADD, COUT | ZIN},
                     {RUNV, NA, ZLOWOUT | GRA | RIN}, F0};
            applyStimulus();
            bus.IR = irs[k];
            for (int i = 0; i < 7; i++) begin
                if (i > 0) begin @(posedge clock); #1; end
                total++;
                if (obsVec() !== expv[i]) begin
                    bad++;
                    $display("[TB] FAIL imm ir=%h step%0d: got %h want %h", irs[k], i, obsVec(), expv[i]);
                end
            end
        end
    endtask

    task automatic test_branch();
        for (int c = 0; c < 2; c++) begin
            logic [25:0] expv [8];
            expv = '{F0, F1, F2, {RUNV, NA, GRA | ROUT | CONIN}, {RUNV, NA, PCOUT | YIN},
                     {RUNV, ADD, COUT | ZIN},
                     {RUNV, NA, (c == 1) ? (ZLOWOUT | PCIN) : 20'h0}, F0};
            applyStimulus();
            bus.IR  = 32'h91800010;
            bus.CON = c[0];
            for (int i = 0; i < 8; i++) begin
                if (i > 0) begin @(posedge clock); #1; end
                total++;
                if (obsVec() !== expv[i]) begin
                    bad++;
                    $display("[TB] FAIL branch con=%0d step%0d: got %h want %h", c, i, obsVec(), expv[i]);
                end
            end
        end
        bus.CON = 1'b0;
    endtask

    task automatic test_halt();
        applyStimulus();
        bus.IR = 32'hD8000000;
        for (int i = 0; i < 14; i++) begin
            logic [25:0] want;
            if (i > 0) begin @(posedge clock); #1; end
            case (i)
                0: want = F0;
                1: want = F1;
                2: want = F2;
                3: want = IDLE;
                default: want = HLTV;
            endcase
            total++;
            if (obsVec() !== want) begin
                bad++;
                $display("[TB] FAIL halt step%0d: got %h want %h", i, obsVec(), want);
            end
        end
        reset_n = 1'b0;
        @(posedge clock); #1;
        total++;
        if (obsVec() !== RSTV) begin
            bad++;
            $display("[TB] FAIL halt_exit_reset: got %h want %h", obsVec(), RSTV);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_stop();
        logic [25:0] expv [9];
        expv = '{F0, F1, F2, {RUNV, NA, GRB | ROUT | YIN}, {RUNV, ADD, GRC | ROUT | ZIN},
                 {RUNV, NA, ZLOWOUT | GRA | RIN}, HLTV, HLTV, HLTV};
        applyStimulus();
        bus.IR   = 32'h1A920000;
        bus.stop = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin @(posedge clock); #1; end
            total++;
            if (obsVec() !== expv[i]) begin
                bad++;
                $display("[TB] FAIL stop step%0d: got %h want %h", i, obsVec(), expv[i]);
            end
        end
        bus.stop = 1'b0;
    endtask

    task automatic checkOutput();
        logic [25:0] expv [9];
        expv = '{F0, F1, F2, {RUNV, NA, GRB | BAOUT | YIN}, {RUNV, ADD, COUT | ZIN},
                 {RUNV, NA, ZLOWOUT | MARIN}, {RUNV, NA, GRA | ROUT | MDRIN},
                 {RUNV, NA, WRITE}, F0};
        applyStimulus();
        bus.IR = 32'h11000055;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin @(posedge clock); #1; end
            total++;
            if (obsVec() !== expv[i]) begin
                bad++;
                $display("[TB] FAIL st step%0d: got %h want %h", i, obsVec(), expv[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [25:0] expv [9];
        expv = '{F0, F1, F2, {RUNV, NA, GRB | BAOUT | YIN}, {RUNV, ADD, COUT | ZIN},
                 {RUNV, NA, ZLOWOUT | MARIN}, {RUNV, NA, GRA | ROUT | MDRIN}, RSTV, F0};
        applyStimulus();
        bus.IR = 32'h11000055;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin @(posedge clock); #1; end
            reset_n = (i == 6) ? 1'b0 : 1'b1;
            total++;
            if (obsVec() !== expv[i]) begin
                bad++;
                $display("[TB] FAIL mid_reset step%0d: got %h want %h", i, obsVec(), expv[i]);
            end
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        bus.IR   = 32'h0;
        bus.CON  = 1'b0;
        bus.stop = 1'b0;
        test_reset();
        test_nop();
        test_ld();
        test_rformat();
        test_immediate();
        test_branch();
        test_halt();
        test_stop();
        checkOutput();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port: clock  in  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset_n  in  1  synchronous active-low reset, sampled on rising clock edge.
REQ-003 SHALL have port: IR  in  32  current instruction word; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15], C IR[18:0].
REQ-004 SHALL have port: CON  in  1  branch-condition flag from the CON flip-flop, valid from the step after CONin.
REQ-005 SHALL have port: stop  in  1  request to halt at the next instruction boundary.
REQ-006 SHALL have ports: Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register select/encode controls.
REQ-007 SHALL have ports: PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout, CONin, Read, Write  out  1 each  datapath strobes.
REQ-008 SHALL have ports: alu_op  out  4  ALU function code; run  out  1  high while executing; clear_out  out  1  datapath clear.

Function
REQ-009 SHALL implement states RST, T0-T7, HALT; all outputs SHALL be combinational decodes of state and IR[31:27]; unlisted outputs 0.
REQ-010 SHALL use fetch: T0 PCout MARin IncPC Zin; T1 Zlowout PCin Read MDRin; T2 MDRout IRin; T2 -> T3 always.
REQ-011 SHALL drive alu_op = 4'b0011 (ADD) in any step asserting Zin except R-format T4, where alu_op = IR[30:27]; otherwise alu_op = 0.
REQ-012 SHALL sequence ld (00000): T3 Grb BAout Yin; T4 Cout Zin; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin; T7 -> T0.
REQ-013 SHALL sequence ldi (00001): T3 Grb BAout Yin; T4 Cout Zin; T5 Zlowout Gra Rin; T5 -> T0.
REQ-014 SHALL sequence st (00010): T3 Grb BAout Yin; T4 Cout Zin; T5 Zlowout MARin; T6 Gra Rout MDRin; T7 Write; T7 -> T0.
REQ-015 SHALL sequence R-format add/sub/and/or (00011-00110): T3 Grb Rout Yin; T4 Grc Rout Zin; T5 Zlowout Gra Rin; T5 -> T0.
REQ-016 SHALL sequence addi (01100): T3 Grb Rout Yin; T4 Cout Zin; T5 Zlowout Gra Rin; T5 -> T0.
REQ-017 SHALL sequence branch (10010): T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zin; T6 Zlowout PCin only if CON=1; T6 -> T0.
REQ-018 SHALL treat nop (11010) and every undefined opcode as T3 with no strobes, T3 -> T0.
REQ-019 SHALL on halt (11011) go T3 -> HALT; HALT holds all strobes 0, run=0, exits only via reset.
REQ-020 SHALL sample stop in the last step of each instruction; if 1, next state HALT instead of T0; stop ignored during T0-T2.
REQ-021 SHALL assert at most one of Gra/Grb/Grc and at most one bus driver (Rout, BAout, PCout, Zlowout, MDRout, Cout) per step.
REQ-022 SHALL never assert Read and Write in the same step; memory has zero wait states (Read data captured at end of same step).
REQ-023 SHALL sample IR opcode only in T3-T7; IR change during T0-T2 SHALL not alter fetch strobes.

Reset
REQ-024 SHALL, when reset_n=0 at a rising edge, enter RST regardless of current state, including mid-instruction and HALT.
REQ-025 SHALL in RST assert clear_out=1, run=0, all other outputs 0; RST -> T0 on first edge with reset_n=1.
REQ-026 SHALL hold run=1 in T0-T7.
REQ-027 SHALL abandon any in-progress instruction on reset with no further Rin, PCin or Write asserted.

Verification
REQ-028 SHALL verify reset/fetch: reset_n low 2 cycles then high -> RST with clear_out=1, then T0 PCout MARin IncPC Zin, T1 Read MDRin, T2 IRin.
REQ-029 SHALL verify ld: IR=0x01000055 (ld R2,0x55(R0)) -> T3 Grb BAout Yin, T4 Cout Zin alu_op=0011, T7 MDRout Gra Rin, next T0.
REQ-030 SHALL verify add: IR=0x1A920000 (add R5,R2,R4) -> T4 Grc Rout alu_op=0011, T5 Gra Rin, 6 cycles T0-T5 total.
REQ-031 SHALL verify branch: IR=0x91800010 with CON=0 -> no PCin in T6; repeat with CON=1 -> T6 Zlowout PCin.
REQ-032 SHALL verify halt/stop: IR=0xD8000000 -> HALT, run=0 held 10 cycles; separately stop=1 during T5 of add -> HALT, not T0.
REQ-033 SHALL verify mid-instruction reset: reset_n=0 during T6 of st -> no Write, next state RST, clear_out=1.
